// File: rtl/clkdiv_sched.sv
// Round-robin owner of the shared PWM clock divider: arbitrates divisor requests
// and applies the granted divisor only at a period wrap, so clk_out never produces a runt period.
module clkdiv_sched #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    div_in,
  output logic [NREQ-1:0]          ack,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [WIDTH-1:0]         cur_div,
  output logic                     clk_out,
  output logic                     tick
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] counter;
  logic [IDW-1:0]   ptr;
  logic [WIDTH-1:0] pend_div;
  logic [IDW-1:0]   pend_id;
  logic [NREQ-1:0]  req_eff;
  logic [WIDTH-1:0] div_arr [NREQ];
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   idx;
  logic             wrap;
  logic             grant;
  logic             apply;

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    return (d < WIDTH'(2)) ? WIDTH'(2) : d;
  endfunction

  assign wrap    = (counter == cur_div - WIDTH'(1));
  // A requester's own req is ignored during its ack cycle, since it may still be high.
  assign req_eff = req & ~ack;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      div_arr[i] = div_in[i*WIDTH +: WIDTH];
    end
  end

  // Walk from the lowest priority back to the pointer so the last hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req_eff[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = PEND;
      PEND:    if (wrap)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == PEND);
    grant = (state == IDLE) && gnt_vld;
    apply = (state == PEND) && wrap;
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      pend_div <= clamp_div(div_arr[gnt_id]);
      pend_id  <= gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // clk_out and tick are registered from the old cur_div on the apply edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      cur_div <= WIDTH'(DEFAULT_DIV);
      owner   <= '0;
      ack     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      counter <= wrap ? '0 : counter + WIDTH'(1);
      clk_out <= (counter < (cur_div >> 1));
      tick    <= wrap;
      ack     <= apply ? (NREQ'(1) << pend_id) : '0;
      if (apply) begin
        cur_div <= pend_div;
        owner   <= pend_id;
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed bench for clkdiv_sched: default divide, single change, round-robin order,
// clamping, reset during a pending grant, grant on the wrap edge and withdrawal.
module tb_clkdiv_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   div_in;
  logic [NREQ-1:0]         ack;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] owner;
  logic [WIDTH-1:0]        cur_div;
  logic                    clk_out;
  logic                    tick;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  logic [31:0] cp, tp;
  logic [NREQ-1:0] acc;

  clkdiv_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEFAULT_DIV(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .div_in  (div_in),
    .ack     (ack),
    .busy    (busy),
    .owner   (owner),
    .cur_div (cur_div),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] d);
    div_in[i*WIDTH +: WIDTH] = d;
    req[i] = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output int cycles, output logic [31:0] pat);
    cycles = 0;
    pat    = '0;
    do begin
      step();
      cycles++;
      pat = {pat[30:0], clk_out};
    end while (ack == '0 && cycles < budget);
  endtask

  task automatic collect(input int n, output logic [31:0] cpat, output logic [31:0] tpat,
                         output logic [NREQ-1:0] acks);
    cpat = '0;
    tpat = '0;
    acks = '0;
    for (int i = 0; i < n; i++) begin
      step();
      cpat = {cpat[30:0], clk_out};
      tpat = {tpat[30:0], tick};
      acks = acks | ack;
    end
  endtask

  task automatic sync_tick(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < budget);
    check("sync_tick", 32'(tick), 1);
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    div_in = '0;
    repeat (3) step();
    check("rst_cur_div", 32'(cur_div), 10);
    check("rst_owner",   32'(owner),   0);
    check("rst_ack",     32'(ack),     0);
    check("rst_busy",    32'(busy),    0);
    check("rst_tick",    32'(tick),    0);
    check("rst_clk_out", 32'(clk_out), 0);

    rst = 1'b0;
    collect(20, cp, tp, acc);
    check("def_clk",   cp, 32'h000F83E0);
    check("def_tick",  tp, 32'h00000401);
    check("def_ack",   32'(acc), 0);
    check("def_div",   32'(cur_div), 10);
    check("def_owner", 32'(owner), 0);

    // Arbitration: all four request together in the counter==0 cycle.
    set_req(0, 4); set_req(1, 5); set_req(2, 6); set_req(3, 7);
    wait_ack(40, cyc, cp);
    check("arb0_cyc", 32'(cyc), 10);
    check("arb0_ack", 32'(ack), 4'b0001);
    check("arb0_clk", cp, 32'h3E0);
    check("arb0_div", 32'(cur_div), 4);
    check("arb0_own", 32'(owner), 0);
    check("arb0_busy", 32'(busy), 0);
    req[0] = 1'b0;
    wait_ack(40, cyc, cp);
    check("arb1_cyc", 32'(cyc), 4);
    check("arb1_ack", 32'(ack), 4'b0010);
    check("arb1_clk", cp, 32'hC);
    check("arb1_div", 32'(cur_div), 5);
    check("arb1_own", 32'(owner), 1);
    req[1] = 1'b0;
    wait_ack(40, cyc, cp);
    check("arb2_cyc", 32'(cyc), 5);
    check("arb2_ack", 32'(ack), 4'b0100);
    check("arb2_clk", cp, 32'h18);
    check("arb2_div", 32'(cur_div), 6);
    check("arb2_own", 32'(owner), 2);
    req[2] = 1'b0;
    wait_ack(40, cyc, cp);
    check("arb3_cyc", 32'(cyc), 6);
    check("arb3_ack", 32'(ack), 4'b1000);
    check("arb3_clk", cp, 32'h38);
    check("arb3_div", 32'(cur_div), 7);
    check("arb3_own", 32'(owner), 3);
    req[3] = 1'b0;
    collect(7, cp, tp, acc);
    check("arb3_per_clk",  cp, 32'h70);
    check("arb3_per_tick", tp, 32'h01);
    check("arb3_per_ack",  32'(acc), 0);
    check("arb3_per_busy", 32'(busy), 0);

    // Single change mid-period (counter==3, cur_div==7).
    repeat (3) step();
    set_req(2, 6);
    step();
    check("one_busy",  32'(busy), 1);
    check("one_ack0",  32'(ack), 0);
    check("one_div0",  32'(cur_div), 7);
    wait_ack(20, cyc, cp);
    check("one_cyc",   32'(cyc), 3);
    check("one_clk0",  cp, 32'h0);
    check("one_ack",   32'(ack), 4'b0100);
    check("one_div",   32'(cur_div), 6);
    check("one_own",   32'(owner), 2);
    check("one_busy0", 32'(busy), 0);
    check("one_tick",  32'(tick), 1);
    req[2] = 1'b0;
    collect(12, cp, tp, acc);
    check("one_per_clk",  cp, 32'hE38);
    check("one_per_tick", tp, 32'h041);
    check("one_per_ack",  32'(acc), 0);

    // Clamp: 0 then 1 both load as 2.
    set_req(3, 0);
    wait_ack(20, cyc, cp);
    check("clamp0_cyc", 32'(cyc), 6);
    check("clamp0_ack", 32'(ack), 4'b1000);
    check("clamp0_clk", cp, 32'h38);
    check("clamp0_div", 32'(cur_div), 2);
    check("clamp0_own", 32'(owner), 3);
    req[3] = 1'b0;
    collect(4, cp, tp, acc);
    check("clamp0_per_clk",  cp, 32'hA);
    check("clamp0_per_tick", tp, 32'h5);
    check("clamp0_per_ack",  32'(acc), 0);
    set_req(0, 1);
    wait_ack(20, cyc, cp);
    check("clamp1_cyc", 32'(cyc), 2);
    check("clamp1_ack", 32'(ack), 4'b0001);
    check("clamp1_clk", cp, 32'h2);
    check("clamp1_div", 32'(cur_div), 2);
    check("clamp1_own", 32'(owner), 0);
    req[0] = 1'b0;
    collect(4, cp, tp, acc);
    check("clamp1_per_clk",  cp, 32'hA);
    check("clamp1_per_tick", tp, 32'h5);

    // Reset while a divisor of 20 is pending.
    set_req(1, 20);
    step();
    check("rp_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    req = '0;
    check("rp_busy0", 32'(busy), 0);
    check("rp_ack",   32'(ack), 0);
    check("rp_div",   32'(cur_div), 10);
    repeat (2) step();
    rst = 1'b0;
    collect(12, cp, tp, acc);
    check("rp_per_ack",  32'(acc), 0);
    check("rp_per_clk",  cp, 32'hF83);
    check("rp_per_tick", tp, 32'h004);
    check("rp_div_after",  32'(cur_div), 10);
    check("rp_busy_after", 32'(busy), 0);

    // Grant latched on the wrap edge applies one full old period later.
    sync_tick(30);
    repeat (9) step();
    check("gw_pre_tick", 32'(tick), 0);
    set_req(1, 8);
    step();
    check("gw_busy", 32'(busy), 1);
    check("gw_ack0", 32'(ack), 0);
    check("gw_div0", 32'(cur_div), 10);
    check("gw_tick", 32'(tick), 1);
    wait_ack(30, cyc, cp);
    check("gw_cyc", 32'(cyc), 10);
    check("gw_ack", 32'(ack), 4'b0010);
    check("gw_clk", cp, 32'h3E0);
    check("gw_div", 32'(cur_div), 8);
    check("gw_own", 32'(owner), 1);
    req[1] = 1'b0;
    collect(8, cp, tp, acc);
    check("gw_per_clk",  cp, 32'hF0);
    check("gw_per_tick", tp, 32'h01);
    check("gw_per_ack",  32'(acc), 0);

    // Withdrawal after grant: value still applied and acked.
    set_req(2, 3);
    step();
    check("wd_busy", 32'(busy), 1);
    req[2] = 1'b0;
    wait_ack(20, cyc, cp);
    check("wd_cyc", 32'(cyc), 7);
    check("wd_ack", 32'(ack), 4'b0100);
    check("wd_div", 32'(cur_div), 3);
    check("wd_own", 32'(owner), 2);
    collect(6, cp, tp, acc);
    check("wd_per_clk",  cp, 32'h24);
    check("wd_per_tick", tp, 32'h09);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_sched.md
# clkdiv_sched

Scheduler and owner of the shared programmable clock divider in the PWM clock tree. Up to NREQ requesters (PWM channels, host config) each ask for a new divisor. The block arbitrates between them round-robin and holds the granted value pending. It applies the value only at a divider period boundary, so clk_out never sees a truncated or runt period. It also produces a one-cycle period-start tick for the downstream PWM counters.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, divisor width in bits
- DEFAULT_DIV, 10, divisor loaded at reset (must be >= 2)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester level request; held until its ack
- div_in  in  NREQ*WIDTH  requested divisors; requester i uses bits [i*WIDTH +: WIDTH]; stable while req[i] high
- ack  out  NREQ  one-cycle pulse: requester's divisor is now in effect
- busy  out  1  a granted divisor is pending
- owner  out  $clog2(NREQ)  index of the requester whose divisor is active
- cur_div  out  WIDTH  active divisor (after clamping)
- clk_out  out  1  divided clock, registered
- tick  out  1  one-cycle pulse in the first cycle of each period

## Operation
- Divider: counter runs 0..cur_div-1, then wraps to 0. Every cycle, clk_out <= (counter < cur_div/2), using integer division. High time is floor(cur_div/2) cycles; period is cur_div cycles.
- tick <= (counter == cur_div-1). tick is therefore high in the cycle where counter == 0.
- Clamping: a requested divisor of 0 or 1 is loaded as 2. No error is flagged.
- FSM, two states:
  - IDLE: if any unmasked req is high, grant the highest-priority one. Latch pend_div <= clamp(div_in[g]) and pend_id <= g, then go to PEND.
  - PEND: busy=1. At the edge where counter == cur_div-1 (the wrap edge), do all of the following together, then return to IDLE:
    - counter <= 0
    - cur_div <= pend_div
    - owner <= pend_id
    - ack[pend_id] <= 1 for one cycle
- Round-robin: a priority pointer resets to 0 and holds the highest-priority index. After a grant to g, the pointer becomes (g+1) mod NREQ.
- Masking: in the cycle where ack[i] is high, req[i] is ignored. A requester must drop req the cycle after its ack.
- Requests arriving while in PEND wait; they are arbitrated in the next IDLE cycle.
- Withdrawal: if a requester drops req after being granted, the latched value is still applied and still acked.
- Reset values: counter=0, cur_div=DEFAULT_DIV, state=IDLE, pointer=0, owner=0, ack=0, busy=0, tick=0, clk_out=0. Reset asserted in PEND discards the pending divisor and sends no ack.

## Timing
- Grant latency: req[i] seen high in cycle t (IDLE) gives grant at the end of t, so busy=1 from t+1.
- Apply latency: the divisor applies at the first wrap edge after entering PEND, at most old cur_div cycles later.
  - If the wrap edge falls at the end of cycle t, the grant is still only latched there. The apply happens on the next wrap.
  - ack, new cur_div, owner and busy=0 all appear together in the cycle after the wrap edge.
- Throughput: at most one divisor change per divider period.
- Period-boundary edge: clk_out's value is registered from the old cur_div. The first full period after the edge uses the new cur_div. tick is high in the first cycle of the new period.
- After reset release, clk_out is 1 from the first edge. The first tick appears DEFAULT_DIV cycles after the first edge.
- A continuous request stream from all requesters gets service in order 0,1,2,3,0,... with no starvation.

## Test plan
- Reset/default: hold rst 3 cycles, release, no req. Required response:
  - clk_out shows 5 cycles high / 5 low, repeating.
  - tick fires once every 10 cycles.
  - cur_div=10, owner=0, ack=0.
- Single change: req[2]=1 with div=6 mid-period.
  - busy rises the next cycle.
  - ack[2] pulses exactly once, the cycle after the wrap edge.
  - The following period is 3 high / 3 low; owner=2, cur_div=6.
  - No period shorter than 6 or 10 cycles appears.
- Arbitration: req[0..3] raised together with divs 4,5,6,7. Required response:
  - Acks arrive in order 0,1,2,3, one per period.
  - Each ack is followed by a full period of the newly acked requester's divisor.
- Clamp: request div=0, then div=1. Required response:
  - cur_div=2 in both cases.
  - clk_out alternates 1 high / 1 low; tick fires every 2 cycles.
- Reset mid-PEND: grant div=20 and assert rst before the wrap edge. Required response:
  - No ack.
  - After release, cur_div=10 and busy=0.
- Grant at the wrap edge: req[1] rises in the cycle with counter==cur_div-1. Required response:
  - The new divisor is applied one full old period later, not at that wrap.
  - ack[1] appears one cycle after the later wrap edge.
